// File: rtl/kernel_config_sequencer_if.sv
// Request, coefficient-write and status signals of the kernel configuration sequencer.
// The master modport is the sequencer side; slave is the control path / coefficient RAM side.
interface kernel_config_sequencer_if;
    logic       req_valid;
    logic [2:0] req_sel;
    logic       req_ready;
    logic       frame_start;
    logic       cfg_wr_valid;
    logic [3:0] cfg_wr_addr;
    logic [7:0] cfg_wr_data;
    logic       cfg_wr_ready;
    logic       pix_enable;
    logic [2:0] active_sel;
    logic       busy;
    logic       sel_err;

    modport master (
        input  req_valid, req_sel, frame_start, cfg_wr_ready,
        output req_ready, cfg_wr_valid, cfg_wr_addr, cfg_wr_data,
        output pix_enable, active_sel, busy, sel_err
    );

    modport slave (
        output req_valid, req_sel, frame_start, cfg_wr_ready,
        input  req_ready, cfg_wr_valid, cfg_wr_addr, cfg_wr_data,
        input  pix_enable, active_sel, busy, sel_err
    );
endinterface

// File: rtl/kernel_config_sequencer.sv
// Holds kernel-select requests until a frame boundary, streams the selected 3x3 kernel plus
// shift word into the convolution engine's coefficient RAM, then masks pixels while it flushes.
module kernel_config_sequencer #(
    parameter int unsigned NUM_KERNELS  = 6,
    parameter int unsigned FLUSH_CYCLES = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    kernel_config_sequencer_if.master        bus_io
);
    localparam int unsigned CntW    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [3:0]  LastIdx = 4'd9;

    typedef enum logic [1:0] {StIdle, StArmed, StLoad, StFlush} state_e;

    // Row-major coefficients at addr 3*row+col, shift word last.
    localparam logic [7:0] KernelTab [6][10] = '{
        '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
        '{8'h01, 8'h02, 8'h01, 8'h02, 8'h04, 8'h02, 8'h01, 8'h02, 8'h01, 8'h04},
        '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'h05, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00},
        '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h08, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00},
        '{8'hFF, 8'h00, 8'h01, 8'hFE, 8'h00, 8'h02, 8'hFF, 8'h00, 8'h01, 8'h00},
        '{8'hFF, 8'hFE, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h01, 8'h00}
    };

    function automatic logic [7:0] coef_word(logic [2:0] sel, logic [3:0] idx);
        if (sel > 3'd5 || idx > LastIdx) return 8'h00;
        return KernelTab[sel][idx];
    endfunction

    state_e          state_q, state_d;
    logic [2:0]      pending_q, pending_d;
    logic [3:0]      idx_q, idx_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            valid_q, valid_d;
    logic [3:0]      addr_q, addr_d;
    logic [7:0]      data_q, data_d;
    logic            pix_q, pix_d;
    logic [2:0]      active_q, active_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;

    logic       accept;
    logic       req_bad;
    logic [2:0] sel_map;

    assign bus_io.req_ready = (state_q == StIdle) || (state_q == StArmed);
    assign accept           = bus_io.req_valid && bus_io.req_ready;
    assign req_bad          = {29'd0, bus_io.req_sel} >= NUM_KERNELS;
    assign sel_map          = req_bad ? 3'd0 : bus_io.req_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StArmed;
            pending_q <= 3'd0;
            idx_q     <= 4'd0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            addr_q    <= 4'd0;
            data_q    <= 8'd0;
            pix_q     <= 1'b0;
            active_q  <= 3'd0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            pix_q     <= pix_d;
            active_q  <= active_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        active_d  = active_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    pending_d = sel_map;
                    state_d   = StArmed;
                end
            end
            StArmed: begin
                // A request coincident with frame_start wins and is the one loaded.
                if (accept) pending_d = sel_map;
                if (bus_io.frame_start) begin
                    state_d = StLoad;
                    idx_d   = 4'd0;
                end
            end
            StLoad: begin
                if (valid_q && bus_io.cfg_wr_ready) begin
                    if (idx_q == LastIdx) begin
                        state_d = StFlush;
                        cnt_d   = CntW'(FLUSH_CYCLES - 1);
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            StFlush: begin
                if (cnt_q == '0) begin
                    state_d  = StIdle;
                    active_d = pending_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StArmed;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_comb begin
        valid_d = (state_d == StLoad);
        addr_d  = valid_d ? idx_d : 4'd0;
        data_d  = valid_d ? coef_word(pending_d, idx_d) : 8'd0;
        busy_d  = (state_d == StLoad) || (state_d == StFlush);
        pix_d   = pix_q;
        if (state_d == StIdle) pix_d = 1'b1;
        else if (busy_d)       pix_d = 1'b0;
        err_d   = accept && req_bad;
    end

    assign bus_io.cfg_wr_valid = valid_q;
    assign bus_io.cfg_wr_addr  = addr_q;
    assign bus_io.cfg_wr_data  = data_q;
    assign bus_io.pix_enable   = pix_q;
    assign bus_io.active_sel   = active_q;
    assign bus_io.busy         = busy_q;
    assign bus_io.sel_err      = err_q;
endmodule

// File: tb/tb_kernel_config_sequencer.sv
// Bench for kernel_config_sequencer: table-driven kernel loads, corner sequences, then random
// traffic, all compared every cycle against a transaction-level model.
module tb_kernel_config_sequencer;
    localparam int NK = 6;
    localparam int FL = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    kernel_config_sequencer_if bus();

    kernel_config_sequencer #(.NUM_KERNELS(NK), .FLUSH_CYCLES(FL)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Kernels as signed 3x3 matrices plus shift.
    int kmat [6][3][3] = '{
        '{'{0, 0, 0},    '{0, 1, 0},    '{0, 0, 0}},
        '{'{1, 2, 1},    '{2, 4, 2},    '{1, 2, 1}},
        '{'{0, -1, 0},   '{-1, 5, -1},  '{0, -1, 0}},
        '{'{-1, -1, -1}, '{-1, 8, -1},  '{-1, -1, -1}},
        '{'{-1, 0, 1},   '{-2, 0, 2},   '{-1, 0, 1}},
        '{'{-1, -2, -1}, '{0, 0, 0},    '{1, 2, 1}}
    };
    int kshift [6] = '{0, 4, 0, 0, 0, 0};

    bit         m_busy, m_armed, m_pix, m_err;
    logic [2:0] m_pending, m_loading, m_active;
    logic [7:0] m_q[$];
    int         m_flush;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_armed = 1; m_pix = 0; m_err = 0;
        m_pending = 0; m_loading = 0; m_active = 0; m_flush = 0;
        m_q.delete();
    endtask

    // Advance the model across one clock edge using the inputs currently driven.
    task automatic model_step();
        bit acc, start;
        acc   = bus.req_valid && !m_busy;
        start = !m_busy && m_armed && bus.frame_start;
        m_err = acc && (int'(bus.req_sel) >= NK);
        if (acc) begin
            m_pending = (int'(bus.req_sel) >= NK) ? 3'd0 : bus.req_sel;
            m_armed   = 1;
        end
        if (start) begin
            m_loading = m_pending;
            m_q.delete();
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++) m_q.push_back(8'(kmat[m_pending][r][c]));
            m_q.push_back(8'(kshift[m_pending]));
            m_busy = 1; m_armed = 0; m_pix = 0;
        end else if (m_busy) begin
            if (m_q.size() > 0) begin
                if (bus.cfg_wr_ready) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) m_flush = FL;
                end
            end else begin
                m_flush--;
                if (m_flush == 0) begin
                    m_busy = 0; m_active = m_loading; m_pix = 1;
                end
            end
        end
    endtask

    task automatic compare_all();
        bit loading;
        loading = m_busy && (m_q.size() > 0);
        check("req_ready", bus.req_ready, !m_busy);
        check("cfg_wr_valid", bus.cfg_wr_valid, loading);
        if (loading) begin
            check("cfg_wr_addr", bus.cfg_wr_addr, 10 - m_q.size());
            check("cfg_wr_data", bus.cfg_wr_data, m_q[0]);
        end
        check("pix_enable", bus.pix_enable, m_pix);
        check("busy", bus.busy, m_busy);
        check("active_sel", bus.active_sel, m_active);
        check("sel_err", bus.sel_err, m_err);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic check_reset_values();
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_cfg_wr_valid", bus.cfg_wr_valid, 0);
        check("rst_cfg_wr_addr", bus.cfg_wr_addr, 0);
        check("rst_cfg_wr_data", bus.cfg_wr_data, 0);
        check("rst_pix_enable", bus.pix_enable, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_active_sel", bus.active_sel, 0);
        check("rst_sel_err", bus.sel_err, 0);
    endtask

    // Drive the write port until the sequencer drops busy, collecting accepted words.
    task automatic run_load(input bit toggle, input bit fs_in_flush,
                            output logic [0:9][7:0] got, output int nwr, output int lc);
        int guard;
        got = '0; nwr = 0; lc = 0; guard = 0;
        while (bus.busy && guard < 400) begin
            if (bus.cfg_wr_valid) begin
                bus.cfg_wr_ready = toggle ? lc[0] : 1'b1;
                lc++;
                if (bus.cfg_wr_ready && nwr < 10) begin
                    got[nwr] = bus.cfg_wr_data;
                    nwr++;
                end
            end else begin
                bus.cfg_wr_ready = 1'b0;
                bus.frame_start  = fs_in_flush && (guard % 3 == 0);
            end
            cycle();
            bus.frame_start = 1'b0;
            guard++;
        end
        check("load_terminates", guard < 400, 1);
        bus.cfg_wr_ready = 1'b1;
    endtask

    typedef struct {
        bit               do_req;
        logic [2:0]       sel;
        bit               toggle;
        logic [0:9][7:0]  data;
        int               load_cycles;
        logic [2:0]       exp_active;
    } vec_t;

    task automatic apply_vec(input vec_t v, input int vi);
        logic [0:9][7:0] got;
        int nwr, lc;
        if (v.do_req) begin
            bus.req_valid = 1; bus.req_sel = v.sel;
            cycle();
            bus.req_valid = 0;
            cycle(); cycle();
        end else begin
            repeat (4) cycle();
        end
        bus.frame_start = 1;
        cycle();
        bus.frame_start = 0;
        run_load(v.toggle, 0, got, nwr, lc);
        check($sformatf("v%0d_write_count", vi), nwr, 10);
        for (int i = 0; i < 10; i++) check($sformatf("v%0d_word%0d", vi, i), got[i], v.data[i]);
        check($sformatf("v%0d_load_cycles", vi), lc, v.load_cycles);
        check($sformatf("v%0d_active_sel", vi), bus.active_sel, v.exp_active);
        check($sformatf("v%0d_pix_enable", vi), bus.pix_enable, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog at %0t: got no finish, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs [6];
        logic [0:9][7:0] got;
        logic [0:9][7:0] ridge;
        logic [0:9][7:0] ident;
        int nwr, lc;

        vecs[0] = '{do_req: 0, sel: 3'd0, toggle: 0, load_cycles: 10, exp_active: 3'd0,
                    data: {8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[1] = '{do_req: 1, sel: 3'd1, toggle: 0, load_cycles: 10, exp_active: 3'd1,
                    data: {8'h01, 8'h02, 8'h01, 8'h02, 8'h04, 8'h02, 8'h01, 8'h02, 8'h01, 8'h04}};
        vecs[2] = '{do_req: 1, sel: 3'd2, toggle: 1, load_cycles: 20, exp_active: 3'd2,
                    data: {8'h00, 8'hFF, 8'h00, 8'hFF, 8'h05, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00}};
        vecs[3] = '{do_req: 1, sel: 3'd7, toggle: 0, load_cycles: 10, exp_active: 3'd0,
                    data: {8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[4] = '{do_req: 1, sel: 3'd4, toggle: 0, load_cycles: 10, exp_active: 3'd4,
                    data: {8'hFF, 8'h00, 8'h01, 8'hFE, 8'h00, 8'h02, 8'hFF, 8'h00, 8'h01, 8'h00}};
        vecs[5] = '{do_req: 1, sel: 3'd5, toggle: 1, load_cycles: 20, exp_active: 3'd5,
                    data: {8'hFF, 8'hFE, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h01, 8'h00}};
        ridge = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h08, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};
        ident = {8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

        bus.req_valid = 0; bus.req_sel = 0; bus.frame_start = 0; bus.cfg_wr_ready = 1;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_values();
        rst_n = 1;

        for (int i = 0; i < 6; i++) apply_vec(vecs[i], i);

        // Last request wins; a request coincident with frame_start is the one loaded.
        bus.req_valid = 1; bus.req_sel = 3'd4; cycle();
        bus.req_sel = 3'd5; cycle();
        bus.req_sel = 3'd3; bus.frame_start = 1; cycle();
        bus.req_valid = 0; bus.frame_start = 0;
        run_load(0, 0, got, nwr, lc);
        check("last_wins_count", nwr, 10);
        for (int i = 0; i < 10; i++) check($sformatf("last_wins_word%0d", i), got[i], ridge[i]);
        check("last_wins_active", bus.active_sel, 3);

        // Reset in the middle of a load, then a clean identity reload with stray frame pulses.
        bus.req_valid = 1; bus.req_sel = 3'd5; cycle();
        bus.req_valid = 0; bus.frame_start = 1; cycle();
        bus.frame_start = 0;
        repeat (4) cycle();
        rst_n = 0;
        #1;
        check_reset_values();
        model_reset();
        @(negedge clk);
        rst_n = 1;
        repeat (2) cycle();
        bus.frame_start = 1; cycle();
        bus.frame_start = 0;
        run_load(0, 1, got, nwr, lc);
        check("post_reset_count", nwr, 10);
        for (int i = 0; i < 10; i++) check($sformatf("post_reset_word%0d", i), got[i], ident[i]);
        repeat (5) cycle();
        check("no_reload_after_flush", bus.busy, 0);

        for (int i = 0; i < 3000; i++) begin
            bus.req_valid    = ($urandom % 8) == 0;
            bus.req_sel      = 3'($urandom % 8);
            bus.frame_start  = ($urandom % 24) == 0;
            bus.cfg_wr_ready = 1'($urandom % 2);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
